// File: rtl/pmp_pkg.sv
// Shared definitions for the sequential PMP checker: cfg byte layout, field
// encodings, FSM state codes and the access-extent helper.
package pmp_pkg;

    localparam int CFG_R     = 0;
    localparam int CFG_W     = 1;
    localparam int CFG_X     = 2;
    localparam int CFG_A_LSB = 3;
    localparam int CFG_L     = 7;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } pmp_a_e;

    typedef enum logic [1:0] {
        ACC_READ    = 2'b00,
        ACC_WRITE   = 2'b01,
        ACC_EXEC    = 2'b10,
        ACC_ILLEGAL = 2'b11
    } pmp_acc_e;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Offset from the first to the last byte touched by an access of this size.
    function automatic logic [1:0] size_last_offset(input logic [1:0] size);
        case (size)
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pmp_tor_match.sv
// Combinational top-of-range matcher: the whole access must lie in [lo, hi)
// and must not wrap past the top of the 32-bit address space.
module pmp_tor_match
    import pmp_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic        match
);

    logic [32:0] last;

    assign last  = {1'b0, addr} + {31'b0, size_last_offset(size)};
    assign match = !last[32] && (addr >= lo) && (last[31:0] < hi);

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: walks entries 0..NUM_ENTRIES-1 one per cycle and
// answers each request with a single allow/hit/entry response.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_size,
    input  logic [1:0]                req_type,
    input  logic                      req_priv_m,
    input  logic [8*NUM_ENTRIES-1:0]  pmpcfg,
    input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_allow,
    output logic                      resp_hit,
    output logic [IDX_W-1:0]          resp_entry,
    output logic [1:0]                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // req_ready is high only in IDLE, resp_valid only in RESP, and response
    // data stays stable while resp_valid is high.
    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      lo;
    logic [31:0]      addr_q;
    logic [1:0]       size_q;
    pmp_acc_e         type_q;
    logic             priv_q;

    logic [7:0]  cfg_arr  [NUM_ENTRIES];
    logic [31:0] addr_arr [NUM_ENTRIES];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_unpack
        assign cfg_arr[i]  = pmpcfg[8*i +: 8];
        assign addr_arr[i] = pmpaddr[32*i +: 32];
    end

    logic [7:0]  cfg_sel;
    logic [31:0] hi;
    logic        tor_match;
    logic        entry_match;
    logic        perm_allow;
    logic        cfg_unused;

    assign cfg_sel    = cfg_arr[idx];
    assign hi         = addr_arr[idx];
    assign cfg_unused = ^cfg_sel[6:5];

    pmp_tor_match u_tor_match (
        .addr  (addr_q),
        .size  (size_q),
        .lo    (lo),
        .hi    (hi),
        .match (tor_match)
    );

    assign entry_match = tor_match && (pmp_a_e'(cfg_sel[CFG_A_LSB +: 2]) == A_TOR);

    // Unlocked entries never restrict machine mode; otherwise the type picks R/W/X.
    always_comb begin
        perm_allow = 1'b0;
        if (priv_q && !cfg_sel[CFG_L]) begin
            perm_allow = 1'b1;
        end else begin
            case (type_q)
                ACC_READ:  perm_allow = cfg_sel[CFG_R];
                ACC_WRITE: perm_allow = cfg_sel[CFG_W];
                ACC_EXEC:  perm_allow = cfg_sel[CFG_X];
                default:   perm_allow = 1'b0;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE) && !rst;
    assign resp_valid = (state == ST_RESP);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            lo         <= '0;
            resp_allow <= 1'b0;
            resp_hit   <= 1'b0;
            resp_entry <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        size_q <= req_size;
                        type_q <= pmp_acc_e'(req_type);
                        priv_q <= req_priv_m;
                        idx    <= '0;
                        lo     <= '0;
                        if (req_size == SIZE_ILLEGAL || req_type == ACC_ILLEGAL) begin
                            resp_allow <= 1'b0;
                            resp_hit   <= 1'b0;
                            resp_entry <= '0;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (entry_match) begin
                        resp_allow <= perm_allow;
                        resp_hit   <= 1'b1;
                        resp_entry <= idx;
                        state      <= ST_RESP;
                    end else if (idx == IDX_W'(NUM_ENTRIES - 1)) begin
                        resp_allow <= priv_q;
                        resp_hit   <= 1'b0;
                        resp_entry <= '0;
                        state      <= ST_RESP;
                    end else begin
                        // This entry's top becomes the next entry's bottom.
                        lo  <= hi;
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Self-checking bench for pmp_seq_checker: directed vector table, hand-built
// multi-cycle sequences and randomized traffic against a reference model.
module tb_pmp_seq_checker;

    localparam int NE = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [1:0]    req_type;
    logic          req_priv_m;
    logic [8*NE-1:0]  pmpcfg;
    logic [32*NE-1:0] pmpaddr;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_allow;
    logic          resp_hit;
    logic [3:0]    resp_entry;
    logic [1:0]    dbg_state;

    logic [7:0]  cfg_a [NE];
    logic [31:0] pa_a  [NE];

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [1:0]  typ;
        logic        priv;
        logic [7:0]  cfg2;
        logic        exp_allow;
        logic        exp_hit;
        logic [3:0]  exp_entry;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    pmp_seq_checker #(.NUM_ENTRIES(NE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_type   (req_type),
        .req_priv_m (req_priv_m),
        .pmpcfg     (pmpcfg),
        .pmpaddr    (pmpaddr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_allow (resp_allow),
        .resp_hit   (resp_hit),
        .resp_entry (resp_entry),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always_comb begin
        pmpcfg  = '0;
        pmpaddr = '0;
        for (int i = 0; i < NE; i++) begin
            pmpcfg[8*i +: 8]   = cfg_a[i];
            pmpaddr[32*i +: 32] = pa_a[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first TOR entry whose [lo,hi) contains the whole access wins.
    // Result packs {allow, hit, entry[3:0], edges-after-accept[7:0]}.
    function automatic logic [13:0] model(input logic [31:0] a, input logic [1:0] s,
                                          input logic [1:0] t, input logic p);
        logic [63:0] last;
        logic [31:0] lo;
        if (s == 2'b11 || t == 2'b11) return 14'd0;
        last = {32'd0, a} + (64'd1 << s) - 64'd1;
        for (int i = 0; i < NE; i++) begin
            lo = (i == 0) ? 32'd0 : pa_a[i-1];
            if (cfg_a[i][4:3] == 2'b01 && last <= 64'hFFFF_FFFF && a >= lo
                && last < {32'd0, pa_a[i]})
                return {((p && !cfg_a[i][7]) ? 1'b1 : cfg_a[i][t]), 1'b1, 4'(i), 8'(i + 1)};
        end
        return {p, 1'b0, 4'd0, 8'(NE)};
    endfunction

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic [1:0] s, input logic [1:0] t,
                          input logic p, input int bp,
                          output logic allow, output logic hit, output logic [3:0] ent,
                          output int lat);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_size   = s;
        req_type   = t;
        req_priv_m = p;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        allow = resp_allow;
        hit   = resp_hit;
        ent   = resp_entry;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            chk("bp_stable", {resp_valid, resp_allow, resp_hit, resp_entry},
                {1'b1, allow, hit, ent});
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("req_ready_after_resp", {req_ready, resp_valid}, 2'b10);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NE; i++) begin
            cfg_a[i] = 8'h00;
            pa_a[i]  = 32'h0;
        end
    endtask

    logic        g_allow;
    logic        g_hit;
    logic [3:0]  g_ent;
    int          g_lat;

    initial begin
        logic [31:0] ra;
        logic [31:0] rm;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic        rp;
        logic [13:0] exp_w;
        logic        seen_resp;

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_type = '0;
        req_priv_m = 1'b0;
        resp_ready = 1'b0;
        clear_cfg();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_outputs", {resp_valid, resp_allow, resp_hit, resp_entry}, 7'd0);
        rst = 1'b0;
        #1;
        chk("req_ready_after_reset", req_ready, 1);

        // ---- directed table: entry 2 TOR over [0x1000, 0x2000) ----
        vecs[0]  = '{32'h0000_1800, 2'b10, 2'b00, 1'b0, 8'h09, 1'b1, 1'b1, 4'd2, 3};
        vecs[1]  = '{32'h0000_1800, 2'b10, 2'b01, 1'b0, 8'h09, 1'b0, 1'b1, 4'd2, 3};
        vecs[2]  = '{32'h0000_1800, 2'b10, 2'b01, 1'b1, 8'h09, 1'b1, 1'b1, 4'd2, 3};
        vecs[3]  = '{32'h0000_1800, 2'b10, 2'b01, 1'b1, 8'h89, 1'b0, 1'b1, 4'd2, 3};
        vecs[4]  = '{32'h0000_0FFF, 2'b00, 2'b00, 1'b0, 8'h09, 1'b0, 1'b0, 4'd0, 16};
        vecs[5]  = '{32'h0000_1FFE, 2'b01, 2'b00, 1'b0, 8'h09, 1'b1, 1'b1, 4'd2, 3};
        vecs[6]  = '{32'h0000_1FFF, 2'b01, 2'b00, 1'b0, 8'h09, 1'b0, 1'b0, 4'd0, 16};
        vecs[7]  = '{32'hFFFF_FFFF, 2'b10, 2'b00, 1'b1, 8'h09, 1'b1, 1'b0, 4'd0, 16};
        vecs[8]  = '{32'h0000_1000, 2'b00, 2'b10, 1'b0, 8'h0D, 1'b1, 1'b1, 4'd2, 3};
        vecs[9]  = '{32'h0000_1004, 2'b10, 2'b10, 1'b0, 8'h0B, 1'b0, 1'b1, 4'd2, 3};
        vecs[10] = '{32'h0000_1800, 2'b11, 2'b00, 1'b0, 8'h09, 1'b0, 1'b0, 4'd0, 0};
        vecs[11] = '{32'h0000_1800, 2'b10, 2'b11, 1'b1, 8'h09, 1'b0, 1'b0, 4'd0, 0};
        vecs[12] = '{32'h0000_3000, 2'b10, 2'b00, 1'b1, 8'h09, 1'b1, 1'b0, 4'd0, 16};
        vecs[13] = '{32'h0000_1800, 2'b10, 2'b00, 1'b1, 8'h88, 1'b0, 1'b1, 4'd2, 3};
        vecs[14] = '{32'h0000_1800, 2'b10, 2'b00, 1'b0, 8'h11, 1'b0, 1'b0, 4'd0, 16};

        pa_a[1] = 32'h0000_1000;
        pa_a[2] = 32'h0000_2000;
        for (int v = 0; v < 15; v++) begin
            cfg_a[2] = vecs[v].cfg2;
            do_req(vecs[v].addr, vecs[v].size, vecs[v].typ, vecs[v].priv, v % 3,
                   g_allow, g_hit, g_ent, g_lat);
            chk($sformatf("vec%0d_allow", v), g_allow, vecs[v].exp_allow);
            chk($sformatf("vec%0d_hit", v), g_hit, vecs[v].exp_hit);
            chk($sformatf("vec%0d_entry", v), g_ent, vecs[v].exp_entry);
            chk($sformatf("vec%0d_latency", v), g_lat, vecs[v].exp_lat);
        end

        // ---- overlap: entries 1 and 3 both cover 0x500, lowest index wins ----
        clear_cfg();
        pa_a[1] = 32'h0000_1000; cfg_a[1] = 8'h09;
        pa_a[2] = 32'h0000_0400;
        pa_a[3] = 32'h0000_0800; cfg_a[3] = 8'h09;
        do_req(32'h500, 2'b10, 2'b00, 1'b0, 0, g_allow, g_hit, g_ent, g_lat);
        chk("overlap_result", {g_allow, g_hit, g_ent}, {1'b1, 1'b1, 4'd1});
        chk("overlap_latency", g_lat, 2);

        // ---- all entries OFF ----
        clear_cfg();
        do_req(32'h500, 2'b10, 2'b00, 1'b0, 0, g_allow, g_hit, g_ent, g_lat);
        chk("alloff_user", {g_allow, g_hit, g_ent}, 6'd0);
        chk("alloff_user_latency", g_lat, NE);
        do_req(32'h500, 2'b10, 2'b00, 1'b1, 0, g_allow, g_hit, g_ent, g_lat);
        chk("alloff_machine", {g_allow, g_hit, g_ent}, {1'b1, 1'b0, 4'd0});

        // ---- illegal size under 5 cycles of backpressure ----
        do_req(32'h500, 2'b11, 2'b00, 1'b1, 5, g_allow, g_hit, g_ent, g_lat);
        chk("illegal_bp_result", {g_allow, g_hit, g_ent}, 6'd0);
        chk("illegal_bp_latency", g_lat, 0);

        // ---- reset in the middle of a scan ----
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h500; req_size = 2'b10;
        req_type = 2'b00; req_priv_m = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_req_ready_low", req_ready, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midscan_rst_outputs", {req_ready, resp_valid}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midscan_rst_ready", req_ready, 1);
        seen_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("midscan_rst_no_resp", seen_resp, 0);

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 60; n++) begin
            if (n % 8 == 0) begin
                for (int i = 0; i < NE; i++) begin
                    pa_a[i]  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                                           : (32'($urandom_range(0, 16'h3FFF)) & ~32'h3);
                    cfg_a[i] = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 1) cfg_a[i][4:3] = 2'b01;
                end
            end
            rs = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            rt = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            rp = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 16'h3FFF));
            rm = (32'd1 << rs) - 32'd1;
            ra = ra & ~rm;
            exp_q.push_back(model(ra, rs, rt, rp));
            do_req(ra, rs, rt, rp, $urandom_range(0, 2), g_allow, g_hit, g_ent, g_lat);
            exp_w = exp_q.pop_front();
            chk($sformatf("rand%0d_addr%0h", n, ra), {g_allow, g_hit, g_ent, 8'(g_lat)}, exp_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmp_seq_checker.md
# pmp_seq_checker

Sequential PMP checker sitting directly upstream of the per-entry TOR address matcher. Accepts one access request per handshake, walks PMP entries from index 0 upward one per cycle, and drives the matcher with the request address/size and the entry's bounds. Consumes the match result, resolves priority and permissions, and returns a single allow/deny response over a valid/ready handshake.

## Interface
- NUM_ENTRIES, 16, number of PMP entries scanned (2..16).
- IDX_W, $clog2(NUM_ENTRIES), width of entry index.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  checker can accept (IDLE only).
- req_addr  input  32  access byte address.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_type  input  2  00 read, 01 write, 10 exec, 11 illegal.
- req_priv_m  input  1  access is machine mode.
- pmpcfg  input  8*NUM_ENTRIES  entry i at [8i+7:8i]: R=bit0, W=bit1, X=bit2, A=bits4:3, L=bit7.
- pmpaddr  input  32*NUM_ENTRIES  entry i at [32i+31:32i]; compared directly against byte addresses.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_allow  output  1  access permitted.
- resp_hit  output  1  some entry matched.
- resp_entry  output  IDX_W  index of matching entry (0 when resp_hit=0).

## Operation
- Clock/reset: one clock; reset is synchronous and active-high.
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. On req_valid: capture addr/size/type/priv_m; idx<=0. Size 11 or type 11 -> RESP with allow=0, hit=0, entry=0; else -> SCAN.
- SCAN: evaluate entry idx each cycle. A=01 (TOR): match iff addr+size (33-bit) does not exceed 32'hFFFFFFFF, addr >= lo, addr+size < hi; lo = pmpaddr[idx-1] (0 for idx 0, irrespective of entry idx-1's A field), hi = pmpaddr[idx]. A=00 (OFF), 10, 11: no match this revision.
- On match: latch hit=1, entry=idx; allow = 1 if priv_m and L=0, else the R/W/X bit selected by type -> RESP.
- No match and idx==NUM_ENTRIES-1: hit=0, entry=0, allow=priv_m -> RESP. Otherwise idx<=idx+1.
- Lowest-index match wins; later entries never evaluated.
- RESP: resp_valid=1; outputs stable until resp_valid&&resp_ready, then -> IDLE.
- pmpcfg/pmpaddr sampled live during SCAN; environment holds them stable from accept to response; behaviour otherwise undefined.

## Timing
- Reset: state IDLE, idx 0, resp_valid 0, resp_allow 0, resp_hit 0, resp_entry 0; req_ready 0 while rst high, 1 the first cycle after.
- Accept in cycle A (req_valid&&req_ready at edge). Hit at entry k: resp_valid first high in cycle A+2+k. Full miss: A+1+NUM_ENTRIES. Illegal size/type: A+1.
- resp_valid held with stable data under backpressure; no timeout.
- req_ready low in SCAN and RESP; response handshake in cycle R -> req_ready high in R+1. Minimum request spacing 3 cycles.
- Reset asserted mid-SCAN/RESP: aborts, no response, next cycle IDLE-reset state.
- req_valid while busy ignored; request must be held by source until accepted.

## Structure
- pmp_pkg: cfg bit positions (R, W, X, L, A_LSB), A-field enum (OFF, TOR, NA4, NAPOT), access type enum, size codes, FSM state enum.
- One sub-module: pmp_tor_match, combinational, single instance fed with latched addr/size, lo, hi; output gated by A==TOR in the checker.
- Index-mux of pmpaddr/pmpcfg in the checker; lo may be a register updated with hi each SCAN step.

## Test plan
- Entry 2 TOR, pmpaddr[1]=0x1000, pmpaddr[2]=0x2000, cfg R=1; user read word at 0x1800 -> hit=1, entry=2, allow=1, resp_valid at A+4.
- Same region, user write at 0x1800, W=0 -> allow=0, hit=1; machine write with L=0 -> allow=1; with L=1 -> allow=0.
- Boundaries: addr=0x0FFF byte -> no hit on entry 2; addr=0x1FFE half (end 0x1FFF) -> hit; addr=0x1FFF half -> miss; addr=0xFFFFFFFF word -> overflow, no hit.
- Overlap: entries 1 and 3 both cover 0x500 (lo 0 for entry 1) -> entry=1, resp_valid at A+3.
- All entries OFF: user read -> hit=0, allow=0 at A+1+NUM_ENTRIES; machine read -> allow=1.
- req_size=11 -> allow=0 at A+1; resp_ready low 5 cycles -> outputs stable; rst mid-SCAN -> no resp_valid, req_ready 1 after reset drops.
